// File: rtl/hazard_pkg.sv
// Shared definitions for the ID/EX hazard and forwarding logic.
// Holds the dependency-code encoding produced by the ID-stage dependency
// detector, the EX forwarding-mux select encoding, and the hazard FSM state
// type. The dependency detector imports these same constants so the two
// ends of the dep_code bus never drift apart.
package hazard_pkg;

  localparam int DEP_W = 6;
  localparam int SEL_W = 3;

  // Dependency codes: where the producer of an ID source operand currently sits
  localparam logic [DEP_W-1:0] DEP_NONE     = 6'd0;
  localparam logic [DEP_W-1:0] DEP_ALU_EX   = 6'd1;
  localparam logic [DEP_W-1:0] DEP_ALU_MEM  = 6'd2;
  localparam logic [DEP_W-1:0] DEP_LOAD_EX  = 6'd3;
  localparam logic [DEP_W-1:0] DEP_LOAD_MEM = 6'd4;
  localparam logic [DEP_W-1:0] DEP_WB       = 6'd5;

  // EX-stage operand mux selects
  localparam logic [SEL_W-1:0] SEL_REGFILE = 3'd0;
  localparam logic [SEL_W-1:0] SEL_MEM_ALU = 3'd1;
  localparam logic [SEL_W-1:0] SEL_WB      = 3'd2;
  localparam logic [SEL_W-1:0] SEL_WB_HOLD = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_DWAIT    = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/fwd_sel_map.sv
// Combinational translation of one operand's dependency code into the EX
// forwarding-mux select.
//   code : dependency code from the ID-stage detector
//   sel  : forwarding-mux select for that operand
//   err  : high when the code is outside the defined range
module fwd_sel_map
  import hazard_pkg::*;
(
  input  logic [DEP_W-1:0] code,
  output logic [SEL_W-1:0] sel,
  output logic             err
);

  // A load still in EX cannot forward anything useful; the stall logic takes
  // care of it, so it reads the regfile path. A load already in MEM has its
  // data arriving in WB by the time the consumer is in EX, hence SEL_WB.
  always_comb begin
    sel = SEL_REGFILE;
    err = 1'b0;
    case (code)
      DEP_NONE:     sel = SEL_REGFILE;
      DEP_ALU_EX:   sel = SEL_MEM_ALU;
      DEP_ALU_MEM:  sel = SEL_WB;
      DEP_LOAD_EX:  sel = SEL_REGFILE;
      DEP_LOAD_MEM: sel = SEL_WB;
      DEP_WB:       sel = SEL_WB_HOLD;
      default: begin
        sel = SEL_REGFILE;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller sitting between ID and EX of the 16-bit 5-stage core.
// Sequences the load-use stall, data-cache freeze and mispredict flush, and
// registers the EX forwarding selects one cycle after ID sees the codes.
//   clk, reset          : core clock, async active-high reset
//   dep_code_rs/rt      : ID operand dependency codes
//   valid_inst_ID       : ID holds a real instruction
//   i_ready             : fetch completed this cycle
//   d_busy              : data cache miss in progress, MEM frozen
//   mispredict_EX       : branch in EX was mispredicted
//   pc_write            : PC update enable
//   ifid_write/flush    : IF/ID latch enable / load bubble
//   idex_write/bubble   : ID/EX latch enable / load bubble
//   fwd_sel_rs/rt       : registered EX forwarding-mux selects
//   dep_err             : sticky, an out-of-range code reached EX
//   stall_cycles        : saturating count of cycles with pc_write low
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEP_W-1:0] dep_code_rs,
  input  logic [DEP_W-1:0] dep_code_rt,
  input  logic             valid_inst_ID,
  input  logic             i_ready,
  input  logic             d_busy,
  input  logic             mispredict_EX,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic [SEL_W-1:0] fwd_sel_rs,
  output logic [SEL_W-1:0] fwd_sel_rt,
  output logic             dep_err,
  output logic [CNT_W-1:0] stall_cycles
);

  hazard_state_t state, next_state;

  logic             load_use;
  logic             pc_w, ifid_w, ifid_f, idex_w, idex_b;
  logic [SEL_W-1:0] map_rs, map_rt;
  logic             err_rs, err_rt;
  logic             advance_real;

  fwd_sel_map u_map_rs (
    .code (dep_code_rs),
    .sel  (map_rs),
    .err  (err_rs)
  );

  fwd_sel_map u_map_rt (
    .code (dep_code_rt),
    .sel  (map_rt),
    .err  (err_rt)
  );

  // The stall is only raised from RUN or DWAIT: once the bubble has been
  // inserted the load has moved on to MEM, so a lingering code 3 is stale.
  assign load_use = valid_inst_ID && (state != ST_LU_STALL) &&
                    ((dep_code_rs == DEP_LOAD_EX) || (dep_code_rt == DEP_LOAD_EX));

  // Priority chain: cache freeze, then mispredict flush, then load-use,
  // then fetch stall. DWAIT behaves like RUN once d_busy drops, so the
  // exiting cycle gets the full evaluation (including a held mispredict).
  always_comb begin
    next_state = ST_RUN;
    pc_w       = 1'b1;
    ifid_w     = 1'b1;
    ifid_f     = 1'b0;
    idex_w     = 1'b1;
    idex_b     = 1'b0;
    if (d_busy) begin
      pc_w       = 1'b0;
      ifid_w     = 1'b0;
      idex_w     = 1'b0;
      next_state = ST_DWAIT;
    end else if (mispredict_EX) begin
      ifid_f = 1'b1;
      idex_b = 1'b1;
    end else if (load_use) begin
      pc_w       = 1'b0;
      ifid_w     = 1'b0;
      idex_b     = 1'b1;
      next_state = ST_LU_STALL;
    end else if (!i_ready) begin
      pc_w   = 1'b0;
      ifid_f = 1'b1;
    end
  end

  // While reset is held the pipeline must stay parked with a bubble queued
  // in ID/EX, independent of whatever the inputs are doing.
  always_comb begin
    pc_write    = pc_w   && !reset;
    ifid_write  = ifid_w && !reset;
    ifid_flush  = ifid_f && !reset;
    idex_write  = idex_w && !reset;
    idex_bubble = idex_b || reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  assign advance_real = idex_w && !idex_b && valid_inst_ID;

  // Forwarding selects follow the instruction into EX. A bubble entering
  // EX reads the regfile; a frozen ID/EX keeps the selects it already has.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_sel_rs <= SEL_REGFILE;
      fwd_sel_rt <= SEL_REGFILE;
    end else if (advance_real) begin
      fwd_sel_rs <= map_rs;
      fwd_sel_rt <= map_rt;
    end else if (idex_w) begin
      fwd_sel_rs <= SEL_REGFILE;
      fwd_sel_rt <= SEL_REGFILE;
    end
  end

  // Sticky error: only a code attached to a real instruction moving into EX
  // is meaningful; codes on bubbles or frozen cycles are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dep_err <= 1'b0;
    end else if (advance_real && (err_rs || err_rt)) begin
      dep_err <= 1'b1;
    end
  end

  // Performance counter of PC-hold cycles, pinned at all-ones once full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_w && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl. Each scenario task walks a small
// stimulus table: combinational controls are compared in the same cycle,
// while the expected forwarding selects are queued at drive time and popped
// after the following clock edge, when the registered outputs appear.
// Control vectors are {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  dep_code_rs, dep_code_rt;
  logic        valid_inst_ID, i_ready, d_busy, mispredict_EX;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic [2:0]  fwd_sel_rs, fwd_sel_rt;
  logic        dep_err;
  logic [15:0] stall_cycles;
  logic [4:0]  ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] rs;
    logic [5:0] rt;
    logic       v;
    logic       ir;
    logic       db;
    logic       mp;
    logic [4:0] ctrl;
    logic [2:0] frs;
    logic [2:0] frt;
  } stim_t;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
  } fwd_exp_t;

  fwd_exp_t sb[$];

  localparam logic [4:0] C_RESET  = 5'b00001;
  localparam logic [4:0] C_NORMAL = 5'b11010;
  localparam logic [4:0] C_LU     = 5'b00011;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_FLUSH  = 5'b11111;
  localparam logic [4:0] C_FETCH  = 5'b01110;

  hazard_fwd_ctrl #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .dep_code_rs   (dep_code_rs),
    .dep_code_rt   (dep_code_rt),
    .valid_inst_ID (valid_inst_ID),
    .i_ready       (i_ready),
    .d_busy        (d_busy),
    .mispredict_EX (mispredict_EX),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_write    (idex_write),
    .idex_bubble   (idex_bubble),
    .fwd_sel_rs    (fwd_sel_rs),
    .fwd_sel_rt    (fwd_sel_rt),
    .dep_err       (dep_err),
    .stall_cycles  (stall_cycles)
  );

  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble};

  always #5 clk = ~clk;

  // Hard time limit so a broken DUT or bench can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input logic [5:0] rs, input logic [5:0] rt,
                               input logic v, input logic ir, input logic db,
                               input logic mp, input logic [4:0] c,
                               input logic [2:0] frs, input logic [2:0] frt);
    stim_t s;
    s.rs = rs; s.rt = rt; s.v = v; s.ir = ir; s.db = db; s.mp = mp;
    s.ctrl = c; s.frs = frs; s.frt = frt;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    dep_code_rs   = s.rs;
    dep_code_rt   = s.rt;
    valid_inst_ID = s.v;
    i_ready       = s.ir;
    d_busy        = s.db;
    mispredict_EX = s.mp;
  endtask

  task automatic drive_idle();
    drive(mk(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd0));
  endtask

  // Entered and left #1 after a rising edge; leaves reset released with the
  // next edge being the first post-reset cycle.
  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #2;
    checks++;
    if (ctrl !== C_RESET) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_RESET);
    end
    checks++;
    if ({fwd_sel_rs, fwd_sel_rt, dep_err, stall_cycles} !== {3'd0, 3'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL reset_regs: got rs=%0d rt=%0d err=%b cnt=%0d expected all 0",
               fwd_sel_rs, fwd_sel_rt, dep_err, stall_cycles);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t    tbl[3];
    fwd_exp_t e;
    do_reset();
    tbl[0] = mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_LU,     3'd0, 3'd0);
    tbl[1] = mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd0);
    tbl[2] = mk(6'd4, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd2, 3'd0);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (ctrl !== tbl[i].ctrl) begin
        errors++;
        $display("[TB] FAIL lu_ctrl[%0d]: got %b expected %b", i, ctrl, tbl[i].ctrl);
      end
      sb.push_back('{rs: tbl[i].frs, rt: tbl[i].frt});
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL lu_fwd[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({fwd_sel_rs, fwd_sel_rt} !== {e.rs, e.rt}) begin
          errors++;
          $display("[TB] FAIL lu_fwd[%0d]: got rs=%0d rt=%0d expected rs=%0d rt=%0d",
                   i, fwd_sel_rs, fwd_sel_rt, e.rs, e.rt);
        end
      end
    end
    checks++;
    if (stall_cycles !== 16'd1) begin
      errors++;
      $display("[TB] FAIL lu_count: got %0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_fwd_rt();
    stim_t    tbl[4];
    fwd_exp_t e;
    do_reset();
    tbl[0] = mk(6'd0, 6'd1, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd1);
    tbl[1] = mk(6'd0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd3);
    tbl[2] = mk(6'd2, 6'd4, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd2, 3'd2);
    tbl[3] = mk(6'd1, 6'd1, 1'b0, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd0);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (ctrl !== tbl[i].ctrl) begin
        errors++;
        $display("[TB] FAIL fwd_ctrl[%0d]: got %b expected %b", i, ctrl, tbl[i].ctrl);
      end
      sb.push_back('{rs: tbl[i].frs, rt: tbl[i].frt});
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL fwd_sel[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({fwd_sel_rs, fwd_sel_rt} !== {e.rs, e.rt}) begin
          errors++;
          $display("[TB] FAIL fwd_sel[%0d]: got rs=%0d rt=%0d expected rs=%0d rt=%0d",
                   i, fwd_sel_rs, fwd_sel_rt, e.rs, e.rt);
        end
      end
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++;
      $display("[TB] FAIL fwd_count: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_dwait();
    stim_t    tbl[7];
    fwd_exp_t e;
    do_reset();
    tbl[0] = mk(6'd1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd1, 3'd0);
    for (int k = 1; k <= 4; k++)
      tbl[k] = mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, C_FREEZE, 3'd1, 3'd0);
    tbl[5] = mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_LU,     3'd0, 3'd0);
    tbl[6] = mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd0);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (ctrl !== tbl[i].ctrl) begin
        errors++;
        $display("[TB] FAIL dwait_ctrl[%0d]: got %b expected %b", i, ctrl, tbl[i].ctrl);
      end
      sb.push_back('{rs: tbl[i].frs, rt: tbl[i].frt});
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL dwait_fwd[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({fwd_sel_rs, fwd_sel_rt} !== {e.rs, e.rt}) begin
          errors++;
          $display("[TB] FAIL dwait_fwd[%0d]: got rs=%0d rt=%0d expected rs=%0d rt=%0d",
                   i, fwd_sel_rs, fwd_sel_rt, e.rs, e.rt);
        end
      end
    end
    checks++;
    if (stall_cycles !== 16'd5) begin
      errors++;
      $display("[TB] FAIL dwait_count: got %0d expected 5", stall_cycles);
    end
  endtask

  task automatic test_mispredict();
    stim_t    tbl[6];
    fwd_exp_t e;
    do_reset();
    tbl[0] = mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, C_FLUSH,  3'd0, 3'd0);
    tbl[1] = mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_LU,     3'd0, 3'd0);
    tbl[2] = mk(6'd1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd1, 3'd0);
    tbl[3] = mk(6'd2, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, C_FREEZE, 3'd1, 3'd0);
    tbl[4] = mk(6'd2, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, C_FLUSH,  3'd0, 3'd0);
    tbl[5] = mk(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd0);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (ctrl !== tbl[i].ctrl) begin
        errors++;
        $display("[TB] FAIL mp_ctrl[%0d]: got %b expected %b", i, ctrl, tbl[i].ctrl);
      end
      sb.push_back('{rs: tbl[i].frs, rt: tbl[i].frt});
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL mp_fwd[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({fwd_sel_rs, fwd_sel_rt} !== {e.rs, e.rt}) begin
          errors++;
          $display("[TB] FAIL mp_fwd[%0d]: got rs=%0d rt=%0d expected rs=%0d rt=%0d",
                   i, fwd_sel_rs, fwd_sel_rt, e.rs, e.rt);
        end
      end
    end
    checks++;
    if (stall_cycles !== 16'd2) begin
      errors++;
      $display("[TB] FAIL mp_count: got %0d expected 2", stall_cycles);
    end
  endtask

  task automatic test_dep_err();
    stim_t    tbl[4];
    fwd_exp_t e;
    do_reset();
    tbl[0] = mk(6'd5, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd3, 3'd0);
    tbl[1] = mk(6'd7, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd0);
    tbl[2] = mk(6'd1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_FETCH,  3'd1, 3'd0);
    tbl[3] = mk(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NORMAL, 3'd0, 3'd0);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      checks++;
      if (ctrl !== tbl[i].ctrl) begin
        errors++;
        $display("[TB] FAIL err_ctrl[%0d]: got %b expected %b", i, ctrl, tbl[i].ctrl);
      end
      sb.push_back('{rs: tbl[i].frs, rt: tbl[i].frt});
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL err_fwd[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({fwd_sel_rs, fwd_sel_rt} !== {e.rs, e.rt}) begin
          errors++;
          $display("[TB] FAIL err_fwd[%0d]: got rs=%0d rt=%0d expected rs=%0d rt=%0d",
                   i, fwd_sel_rs, fwd_sel_rt, e.rs, e.rt);
        end
      end
    end
    checks++;
    if (dep_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b expected 1", dep_err);
    end
    checks++;
    if (stall_cycles !== 16'd1) begin
      errors++;
      $display("[TB] FAIL err_count: got %0d expected 1", stall_cycles);
    end
    do_reset();
    checks++;
    if (dep_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got %b expected 0", dep_err);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    // Enter LU_STALL, then pulse reset mid-cycle
    drive(mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_LU, 3'd0, 3'd0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({ctrl, stall_cycles} !== {C_RESET, 16'd0}) begin
      errors++;
      $display("[TB] FAIL abort_lu: got ctrl=%b cnt=%0d expected ctrl=%b cnt=0",
               ctrl, stall_cycles, C_RESET);
    end
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NORMAL) begin
      errors++;
      $display("[TB] FAIL abort_lu_idle: got %b expected %b", ctrl, C_NORMAL);
    end
    // A code 3 right after release must stall, proving the state is RUN
    drive(mk(6'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_LU, 3'd0, 3'd0));
    #1;
    checks++;
    if (ctrl !== C_LU) begin
      errors++;
      $display("[TB] FAIL abort_lu_state: got %b expected %b", ctrl, C_LU);
    end
    @(posedge clk);
    #1;
    // Enter DWAIT, then pulse reset with d_busy still high
    drive(mk(6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE, 3'd0, 3'd0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({ctrl, stall_cycles, fwd_sel_rs} !== {C_RESET, 16'd0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL abort_dwait: got ctrl=%b cnt=%0d rs=%0d expected ctrl=%b cnt=0 rs=0",
               ctrl, stall_cycles, fwd_sel_rs, C_RESET);
    end
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NORMAL) begin
      errors++;
      $display("[TB] FAIL abort_dwait_idle: got %b expected %b", ctrl, C_NORMAL);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] hazard_fwd_ctrl bench starting");
    test_reset();
    test_load_use();
    test_fwd_rt();
    test_dwait();
    test_mispredict();
    test_dep_err();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard controller between ID and EX of the 16-bit 5-stage core. Consumes per-operand dependency codes from the ID-stage dependency detector plus cache and branch status. Produces PC / IF-ID / ID-EX write, flush and bubble controls, and registered EX-stage forwarding-mux selects. Owns the load-use stall, data-cache wait and mispredict-flush sequencing, and keeps a stall-cycle performance counter.

## Interface
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dep_code_rs` in 6: ID rs dependency code. 0 none, 1 ALU result in EX, 2 ALU result in MEM, 3 load in EX, 4 load in MEM, 5 WB.
- `dep_code_rt` in 6: same encoding for rt.
- `valid_inst_ID` in 1: the ID instruction is real, not a bubble.
- `i_ready` in 1: instruction fetch completed this cycle.
- `d_busy` in 1: data cache is servicing a miss; MEM cannot complete.
- `mispredict_EX` in 1: branch resolved in EX was mispredicted.
- `pc_write` out 1: PC update enable.
- `ifid_write` out 1: IF/ID latch enable.
- `ifid_flush` out 1: load a bubble into IF/ID.
- `idex_write` out 1: ID/EX latch enable.
- `idex_bubble` out 1: load a bubble into ID/EX instead of the ID instruction.
- `fwd_sel_rs` out 3: EX rs mux select. 0 regfile, 1 MEM ALU result, 2 WB value, 3 WB-hold latch.
- `fwd_sel_rt` out 3: same encoding for rt.
- `dep_err` out 1: sticky flag; a code >5 was seen.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_write`=0.

## Operation
- FSM states:
  - RUN: normal flow.
  - LU_STALL: one load-use bubble.
  - DWAIT: whole pipeline frozen on the data cache.
- Each cycle, evaluate conditions in priority order; the first match wins:
  1. `d_busy`=1: all write enables 0, no flush, no bubble, `fwd_sel` held. Next state DWAIT, and stays there while `d_busy`=1.
  2. `mispredict_EX`=1: `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1. Next state RUN. This overrides a pending load-use.
  3. Load-use:
     - Condition: `valid_inst_ID`=1, state is not LU_STALL, and (`dep_code_rs`==3 or `dep_code_rt`==3).
     - Controls: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
     - Next state LU_STALL.
  4. `i_ready`=0: `pc_write`=0, `ifid_flush`=1, ID/EX advances normally. Next state RUN.
  5. Otherwise: all enables 1, no flush, no bubble. Next state RUN.
- LU_STALL lasts exactly one cycle. A code 3 still present in LU_STALL is not acted on again; it returns to RUN.
- DWAIT exits to RUN on the first cycle with `d_busy`=0; that cycle is then evaluated normally.
- Forwarding-select mapping, applied when ID/EX advances with a non-bubble instruction (bubble gives 0 for both selects):
  - code 0 → 0
  - code 1 → 1
  - code 2 → 2
  - code 4 → 2
  - code 5 → 3
  - code 3 → 0 (a stall is already in progress)
  - code >5 → 0, and sets `dep_err`
- `dep_err` clears only on reset.
- `stall_cycles` increments on every cycle with `pc_write`=0 and saturates at all-ones.

## Timing
- Control outputs are combinational from state and inputs, valid in the same cycle.
- `fwd_sel_*` are registered with 1-cycle latency: the ID code in cycle N drives the EX mux in cycle N+1.
- Reset values, applied asynchronously and held while `reset`=1:
  - state RUN
  - `pc_write`=0, `ifid_write`=0, `idex_write`=0
  - `ifid_flush`=0, `idex_bubble`=1
  - `fwd_sel_rs`=0, `fwd_sel_rt`=0
  - `dep_err`=0, `stall_cycles`=0
- Reset asserted mid-stall or in DWAIT aborts the sequence. The first cycle after release is evaluated from RUN.
- `d_busy` together with `mispredict_EX`: the freeze wins, and the flush is applied on the first cycle with `d_busy`=0, with `mispredict_EX` still asserted by the held EX stage.
- A load-use stall takes exactly 1 cycle. Fetch-stall cycles and DWAIT cycles add to the stall count without limit.

## Structure
- The shared package `hazard_pkg` holds:
  - the dependency-code constants 0..5 with width 6
  - the forwarding-select constants 0..3 with width 3
  - the FSM state encoding
- The ID-stage dependency detector imports the same dependency-code constants; no local redefinition.
- One sub-module, `fwd_sel_map`: purely combinational code-to-select mapping plus an error bit, instantiated once per operand.

## Test plan
- rs code 3, `valid_inst_ID`=1, other inputs idle → one cycle with `pc_write`=0 and `idex_bubble`=1. Then rs code 4 → `fwd_sel_rs`=2 on the next cycle. `stall_cycles`=1.
- rt code 1, then rt code 5 on consecutive cycles → `fwd_sel_rt` is 1 then 3, each one cycle later. No stall.
- `d_busy` high for 4 cycles while rs code 3 is pending → write enables 0 for 4 cycles with no bubble, then a 1-cycle load-use stall. `stall_cycles`=5.
- `mispredict_EX`=1 together with rs code 3 → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1. No LU_STALL entry.
- rs code 7 → `fwd_sel_rs`=0 and `dep_err`=1, which stays set until `reset`.
- `reset` pulsed high in LU_STALL and in DWAIT → immediate reset values. The first post-reset cycle with all-idle inputs gives all enables 1.
